// File: rtl/seg_pkg.sv
// Shared constants and types for the 6-digit multiplexed 7-segment display driver.
package seg_pkg;

  localparam int NUM_DIG = 6;

  // Hex glyphs, bit order gfedcba; entry 0 sits in the least-significant slot
  localparam logic [15:0][6:0] SEG7_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef enum logic {
    ST_BLANK,
    ST_DRIVE
  } seg_state_t;

  typedef struct packed {
    logic [NUM_DIG*4-1:0] digits;
    logic [NUM_DIG-1:0]   dp;
    logic [NUM_DIG-1:0]   blink;
    logic                 lzb;
  } disp_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to 7-segment glyph lookup.
module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG7_TABLE[nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// Scans six hex digits one slot at a time with anti-ghost blanking, leading-zero
// suppression and per-digit blink; display data changes only at frame boundaries.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYC    = 500,
  parameter int BLINK_FRAMES = 83
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] i_digits,
  input  logic [5:0]  i_dp,
  input  logic [5:0]  i_blink,
  input  logic        i_lzb,
  input  logic        i_load,
  output logic [6:0]  o_seg,
  output logic        o_seg_dp,
  output logic [5:0]  o_seg_enb,
  output logic        o_frame_start
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_MAX    = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [FW-1:0] FCNT_MAX   = FW'(BLINK_FRAMES - 1);
  localparam logic [2:0]    IDX_MAX    = 3'(NUM_DIG - 1);

  logic [CW-1:0] cnt_reg;
  logic [2:0]    idx_reg;
  logic [FW-1:0] fcnt_reg;
  logic          phase_on_reg;
  logic          started_reg;
  seg_state_t    state_reg, state_next;
  disp_t         shadow_reg, frame_reg;

  logic               slot_wrap, frame_wrap;
  logic [NUM_DIG-1:0] lead_zero, suppress;
  logic [3:0]         cur_nibble;
  logic [6:0]         cur_glyph;
  logic [6:0]         seg_next;
  logic [5:0]         enb_next;
  logic               dp_next;

  assign slot_wrap  = (cnt_reg == CNT_MAX);
  assign frame_wrap = slot_wrap && (idx_reg == IDX_MAX);

  // Digit k is a leading zero when it and every digit to its left are zero
  assign lead_zero[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < NUM_DIG; gi++) begin : g_lz
      assign lead_zero[gi] = (frame_reg.digits[NUM_DIG*4-1:gi*4] == '0);
    end
    for (genvar gi = 0; gi < NUM_DIG; gi++) begin : g_sup
      assign suppress[gi] = (frame_reg.lzb && lead_zero[gi]) ||
                            (!phase_on_reg && frame_reg.blink[gi]);
    end
  endgenerate

  assign cur_nibble = frame_reg.digits[{idx_reg, 2'b00} +: 4];

  seg7_decode u_decode (
    .nibble (cur_nibble),
    .seg    (cur_glyph)
  );

  always_comb begin
    state_next = state_reg;
    enb_next   = 6'h3F;
    seg_next   = '0;
    dp_next    = 1'b0;
    case (state_reg)
      ST_BLANK: begin
        if (cnt_reg == BLANK_LAST) state_next = ST_DRIVE;
      end
      ST_DRIVE: begin
        if (slot_wrap) state_next = ST_BLANK;
        if (!suppress[idx_reg]) begin
          enb_next = ~(6'b000001 << idx_reg);
          seg_next = cur_glyph;
          dp_next  = frame_reg.dp[idx_reg];
        end
      end
      default: state_next = ST_BLANK;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_BLANK;
      cnt_reg   <= '0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= slot_wrap ? '0 : cnt_reg + 1'b1;
      if (slot_wrap) idx_reg <= (idx_reg == IDX_MAX) ? 3'd0 : idx_reg + 3'd1;
    end
  end

  // Frame regs take the shadow value held before any same-edge load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_reg   <= '0;
      frame_reg    <= '0;
      fcnt_reg     <= '0;
      phase_on_reg <= 1'b1;
      started_reg  <= 1'b0;
    end else begin
      if (i_load) shadow_reg <= '{digits: i_digits, dp: i_dp, blink: i_blink, lzb: i_lzb};
      if (frame_wrap) begin
        frame_reg   <= shadow_reg;
        started_reg <= 1'b1;
        if (fcnt_reg == FCNT_MAX) begin
          fcnt_reg     <= '0;
          phase_on_reg <= ~phase_on_reg;
        end else begin
          fcnt_reg <= fcnt_reg + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_seg_enb     <= 6'h3F;
      o_seg         <= '0;
      o_seg_dp      <= 1'b0;
      o_frame_start <= 1'b0;
    end else begin
      o_seg_enb     <= enb_next;
      o_seg         <= seg_next;
      o_seg_dp      <= dp_next;
      o_frame_start <= (cnt_reg == '0) && (idx_reg == 3'd0) && started_reg;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench: stimulus pushes hand-computed per-cycle drive expectations for each frame,
// a negedge monitor pops one entry on every driven cycle and checks frame_start spacing.
module tb_seg_scan_driver;

  localparam int FRAME_CLKS = 48;

  typedef struct packed {
    logic [5:0] enb;
    logic [6:0] seg;
    logic       dp;
  } drv_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] i_digits;
  logic [5:0]  i_dp;
  logic [5:0]  i_blink;
  logic        i_lzb;
  logic        i_load;
  logic [6:0]  o_seg;
  logic        o_seg_dp;
  logic [5:0]  o_seg_enb;
  logic        o_frame_start;

  int   n_vec = 0;
  int   n_err = 0;
  drv_t exp_q[$];

  always #5 clk = ~clk;

  seg_scan_driver #(.SCAN_DIV(8), .BLANK_CYC(2), .BLINK_FRAMES(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_digits      (i_digits),
    .i_dp          (i_dp),
    .i_blink       (i_blink),
    .i_lzb         (i_lzb),
    .i_load        (i_load),
    .o_seg         (o_seg),
    .o_seg_dp      (o_seg_dp),
    .o_seg_enb     (o_seg_enb),
    .o_frame_start (o_frame_start)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // segs[i] is the glyph digit i must show; 0 marks a digit whose slot stays blank
  task automatic push_frame(input logic [5:0][6:0] segs, input logic [5:0] dps);
    drv_t e;
    for (int i = 0; i < 6; i++) begin
      if (segs[i] != 7'h00) begin
        e.enb = ~(6'b000001 << i);
        e.seg = segs[i];
        e.dp  = dps[i];
        repeat (6) exp_q.push_back(e);
      end
    end
  endtask

  task automatic load(input logic [23:0] d, input logic [5:0] dp, input logic [5:0] bl,
                      input logic lzb);
    i_digits = d;
    i_dp     = dp;
    i_blink  = bl;
    i_lzb    = lzb;
    i_load   = 1'b1;
    @(negedge clk);
    i_load   = 1'b0;
  endtask

  task automatic wait_frame(input string name);
    bit found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (o_frame_start) begin
        found = 1'b1;
        break;
      end
    end
    chk({name, "_frame_start_seen"}, 32'(found), 32'd1);
  endtask

  // Monitor
  initial begin
    int   cyc = 0;
    int   last_fs = -1;
    drv_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        last_fs = -1;
      end else begin
        if (o_frame_start) begin
          if (last_fs >= 0) chk("frame_period", 32'(cyc - last_fs), 32'(FRAME_CLKS));
          last_fs = cyc;
        end
        if (o_seg_enb != 6'h3F) begin
          n_vec++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_drive: enb=%02h seg=%02h dp=%0b with nothing expected at %0t",
                     o_seg_enb, o_seg, o_seg_dp, $time);
          end else begin
            e = exp_q.pop_front();
            if (o_seg_enb !== e.enb || o_seg !== e.seg || o_seg_dp !== e.dp) begin
              n_err++;
              $display("FAIL drive: enb=%02h seg=%02h dp=%0b expected enb=%02h seg=%02h dp=%0b at %0t",
                       o_seg_enb, o_seg, o_seg_dp, e.enb, e.seg, e.dp, $time);
            end else begin
              $display("ok   drive: enb=%02h seg=%02h dp=%0b", o_seg_enb, o_seg, o_seg_dp);
            end
          end
        end else if (o_seg != 7'h00 || o_seg_dp != 1'b0) begin
          n_vec++;
          n_err++;
          $display("FAIL blank_slot: seg=%02h dp=%0b while enb=3F at %0t", o_seg, o_seg_dp, $time);
        end
      end
    end
  end

  // Stimulus
  initial begin
    rst_n    = 1'b0;
    i_digits = '0;
    i_dp     = '0;
    i_blink  = '0;
    i_lzb    = 1'b0;
    i_load   = 1'b0;

    repeat (5) begin
      @(negedge clk);
      chk("reset_enb", 32'(o_seg_enb), 32'h3F);
      chk("reset_seg", 32'(o_seg), 32'h00);
      chk("reset_dp", 32'(o_seg_dp), 32'h0);
      chk("reset_fs", 32'(o_frame_start), 32'h0);
    end

    rst_n = 1'b1;
    push_frame({6{7'h3F}}, 6'b000000);
    load(24'h123456, 6'b000100, 6'b000000, 1'b0);

    wait_frame("f1");
    push_frame({7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D}, 6'b000100);
    repeat (27) @(negedge clk);
    load(24'hAAAAAA, 6'b000000, 6'b000000, 1'b0);

    wait_frame("f2");
    push_frame({6{7'h77}}, 6'b000000);
    repeat (46) @(negedge clk);
    load(24'h000050, 6'b000000, 6'b000000, 1'b1);

    wait_frame("f3");
    push_frame({6{7'h77}}, 6'b000000);

    wait_frame("f4");
    push_frame({7'h00, 7'h00, 7'h00, 7'h00, 7'h6D, 7'h3F}, 6'b000000);
    load(24'h000000, 6'b000000, 6'b000000, 1'b1);

    wait_frame("f5");
    push_frame({7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h3F}, 6'b000000);
    load(24'h000008, 6'b000000, 6'b000001, 1'b0);

    wait_frame("f6");
    push_frame({7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h00}, 6'b000000);
    wait_frame("f7");
    push_frame({7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h00}, 6'b000000);
    wait_frame("f8");
    push_frame({7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h7F}, 6'b000000);
    wait_frame("f9");
    push_frame({7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h7F}, 6'b000000);

    wait_frame("f10");
    push_frame({7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h00}, 6'b000000);
    repeat (28) @(negedge clk);
    #2;
    chk("slot3_drive_enb", 32'(o_seg_enb), 32'h37);
    rst_n = 1'b0;
    #1;
    chk("async_rst_enb", 32'(o_seg_enb), 32'h3F);
    chk("async_rst_seg", 32'(o_seg), 32'h00);
    chk("async_rst_dp", 32'(o_seg_dp), 32'h0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    chk("rst_hold_fs", 32'(o_frame_start), 32'h0);

    rst_n = 1'b1;
    push_frame({6{7'h3F}}, 6'b000000);
    wait_frame("post_rst_f1");
    push_frame({6{7'h3F}}, 6'b000000);
    wait_frame("post_rst_f2");
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
